// File: rtl/fb_access_ctrl.sv
// fb_access_ctrl: double-buffered frame buffer write arbitration, clear engine, front/back swap and VGA read addressing
module fb_access_ctrl #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int FB_WORDS = 307200,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [9:0]        pix_x,
  input  logic [8:0]        pix_y,
  input  logic [1:0]        pix_r,
  input  logic [1:0]        pix_g,
  input  logic [1:0]        pix_b,
  input  logic              clear_req,
  input  logic [5:0]        clear_color,
  output logic              clear_busy,
  input  logic              swap_req,
  output logic              swap_pending,
  input  logic              vblank,
  input  logic [9:0]        vga_x,
  input  logic [8:0]        vga_y,
  output logic              front_sel,
  output logic [ADDR_W-1:0] read_addr,
  output logic              we_2,
  output logic [ADDR_W-1:0] write_addr,
  output logic [1:0]        data_in_r,
  output logic [1:0]        data_in_g,
  output logic [1:0]        data_in_b
);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [5:0] r_color;
  logic r_vb_d;
  logic w_idle, w_pix_in, w_pix_wr, w_vga_in, w_swap, w_clear_last;
  logic [ADDR_W-1:0] w_back, w_front, w_pix_off, w_vga_off;
  assign w_idle       = r_state == S_IDLE;
  assign w_back       = front_sel ? '0 : ADDR_W'(FB_WORDS);
  assign w_front      = front_sel ? ADDR_W'(FB_WORDS) : '0;
  assign w_pix_in     = pix_x < 10'(H_RES) && pix_y < 9'(V_RES);
  assign w_vga_in     = vga_x < 10'(H_RES) && vga_y < 9'(V_RES);
  assign w_pix_off    = ADDR_W'(pix_y) * ADDR_W'(H_RES) + ADDR_W'(pix_x);
  assign w_vga_off    = ADDR_W'(vga_y) * ADDR_W'(H_RES) + ADDR_W'(vga_x);
  assign w_pix_wr     = pix_valid && pix_ready && w_pix_in;
  assign w_clear_last = r_cnt == ADDR_W'(FB_WORDS - 1);
  // swap only while idle, on a fresh vblank rise, for a request registered before this cycle
  assign w_swap       = vblank && !r_vb_d && swap_pending && w_idle;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state: clear_req only honoured while idle, clear ends after the last word
  always_comb
    w_next = w_idle ? (clear_req ? S_CLEAR : S_IDLE) : (w_clear_last ? S_IDLE : S_CLEAR);
  // combinational handshake output
  always_comb
    pix_ready = w_idle;
  // write port: clear engine owns it in CLEAR, accepted in-range pixels otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_2 <= 1'b0;
      write_addr <= '0;
      {data_in_r, data_in_g, data_in_b} <= '0;
    end else begin
      we_2 <= !w_idle || w_pix_wr;
      if (!w_idle) begin
        write_addr <= w_back + r_cnt;
        {data_in_r, data_in_g, data_in_b} <= r_color;
      end else if (w_pix_wr) begin
        write_addr <= w_back + w_pix_off;
        {data_in_r, data_in_g, data_in_b} <= {pix_r, pix_g, pix_b};
      end
    end
  // clear engine: colour and counter captured on clear start, counter walks the back buffer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_color <= '0;
      clear_busy <= 1'b0;
    end else begin
      clear_busy <= w_next == S_CLEAR;
      if (w_idle && clear_req) begin
        r_cnt <= '0;
        r_color <= clear_color;
      end else if (!w_idle) r_cnt <= r_cnt + 1'b1;
    end
  // swap bookkeeping and vblank edge register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_vb_d <= 1'b0;
      front_sel <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      r_vb_d <= vblank;
      front_sel <= front_sel ^ w_swap;
      swap_pending <= !w_swap && (swap_pending || swap_req);
    end
  // VGA read address into the front buffer, base only when off-screen
  always_ff @(posedge clk or posedge rst)
    if (rst) read_addr <= '0;
    else read_addr <= w_front + (w_vga_in ? w_vga_off : '0);
endmodule

// File: tb/tb_fb_access_ctrl.sv
// tb_fb_access_ctrl: scoreboard bench for fb_access_ctrl on a reduced 20x12 frame
module tb_fb_access_ctrl;
  localparam int H  = 20;
  localparam int V  = 12;
  localparam int FB = H * V;
  logic clk = 0;
  logic rst = 1;
  logic pix_valid = 0, pix_ready;
  logic [9:0] pix_x = 0, vga_x = 0;
  logic [8:0] pix_y = 0, vga_y = 0;
  logic [1:0] pix_r = 0, pix_g = 0, pix_b = 0;
  logic clear_req = 0, clear_busy, swap_req = 0, swap_pending, vblank = 0, front_sel, we_2;
  logic [5:0] clear_color = 0;
  logic [19:0] read_addr, write_addr;
  logic [1:0] data_in_r, data_in_g, data_in_b;
  int total = 0, bad = 0;

  fb_access_ctrl #(.H_RES(H), .V_RES(V), .FB_WORDS(FB), .ADDR_W(20)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
    .swap_req(swap_req), .swap_pending(swap_pending), .vblank(vblank),
    .vga_x(vga_x), .vga_y(vga_y), .front_sel(front_sel), .read_addr(read_addr),
    .we_2(we_2), .write_addr(write_addr),
    .data_in_r(data_in_r), .data_in_g(data_in_g), .data_in_b(data_in_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask

  // reference model: remaining clear words, displayed buffer, pending request, expected writes
  logic [25:0] wq[$];
  int m_rem = 0, m_read = 0;
  bit m_front = 0, m_pend = 0, m_pvb = 0;
  logic [5:0] m_col = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0; m_front = 0; m_pend = 0; m_pvb = 0; m_col = 0; m_read = 0;
      wq.delete();
    end else begin
      int back;
      bit idle_now;
      back = m_front ? 0 : FB;
      idle_now = m_rem == 0;
      m_read = (m_front ? FB : 0) + ((vga_x < H && vga_y < V) ? vga_y * H + vga_x : 0);
      if (!idle_now) begin
        wq.push_back({20'(back + FB - m_rem), m_col});
        m_rem--;
      end else begin
        if (pix_valid && pix_x < H && pix_y < V)
          wq.push_back({20'(back + pix_y * H + pix_x), pix_r, pix_g, pix_b});
        if (clear_req) begin
          m_rem = FB;
          m_col = clear_color;
        end
      end
      if (vblank && !m_pvb && m_pend && idle_now) begin
        m_front = !m_front;
        m_pend = 0;
      end else if (swap_req) m_pend = 1;
      m_pvb = vblank;
    end
  end

  // monitor: compare registered state every cycle, pop the scoreboard on each write
  always @(negedge clk) begin
    chk("pix_ready", pix_ready, m_rem == 0);
    chk("clear_busy", clear_busy, m_rem != 0);
    chk("swap_pending", swap_pending, m_pend);
    chk("front_sel", front_sel, m_front);
    chk("read_addr", read_addr, m_read);
    if (we_2 || wq.size() != 0) begin
      chk("we_2", we_2, wq.size() != 0);
      if (we_2 && wq.size() != 0) chk("write", {write_addr, data_in_r, data_in_g, data_in_b}, wq.pop_front());
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
    pix_valid = 0; clear_req = 0; swap_req = 0;
  endtask

  task automatic wait_clear_done(input string n);
    int k = 0;
    while (clear_busy && k < 4 * FB) begin cyc(); k++; end
    chk(n, clear_busy, 0);
  endtask

  initial begin
    int cnt;
    cyc(3);
    rst = 0;
    // first pixel straight after reset
    pix_valid = 1; pix_x = 5; pix_y = 2; {pix_r, pix_g, pix_b} = {2'd3, 2'd1, 2'd2};
    cyc();
    chk("first_we", we_2, 1);
    chk("first_addr", write_addr, FB + 2 * H + 5);
    chk("first_data", {data_in_r, data_in_g, data_in_b}, {2'd3, 2'd1, 2'd2});
    // out-of-range then last pixel
    pix_valid = 1; pix_x = H; pix_y = 0;
    cyc();
    chk("oor_we", we_2, 0);
    pix_valid = 1; pix_x = H - 1; pix_y = V - 1;
    cyc();
    chk("last_addr", write_addr, 2 * FB - 1);
    // full clear with white, pixels offered throughout
    clear_req = 1; clear_color = 6'h3f;
    cyc();
    cnt = 0;
    while (clear_busy && cnt < 4 * FB) begin
      pix_valid = 1; pix_x = 1; pix_y = 1;
      cyc(); cnt++;
    end
    chk("clear_len", cnt, FB);
    // swap on vblank rise
    swap_req = 1;
    cyc();
    vblank = 1;
    cyc(2);
    chk("swap_front", front_sel, 1);
    vblank = 0;
    pix_valid = 1; pix_x = 0; pix_y = 0; vga_x = 0; vga_y = 0;
    cyc();
    chk("swap_pix_addr", write_addr, 0);
    chk("swap_read_addr", read_addr, FB);
    // swap requested during a clear, vblank rises mid-clear
    clear_req = 1; clear_color = 6'h15;
    cyc();
    swap_req = 1;
    cyc(40);
    vblank = 1;
    cyc(3);
    chk("midclear_front", front_sel, 1);
    chk("midclear_pend", swap_pending, 1);
    vblank = 0;
    wait_clear_done("clear2_done");
    cyc(2);
    vblank = 1;
    cyc(2);
    chk("post_clear_swap", front_sel, 0);
    vblank = 0;
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      pix_valid = $urandom_range(0, 3) != 0;
      pix_x = 10'($urandom_range(0, H + 2));
      pix_y = 9'($urandom_range(0, V + 2));
      {pix_r, pix_g, pix_b} = 6'($urandom);
      clear_req = $urandom_range(0, 299) == 0;
      clear_color = 6'($urandom);
      swap_req = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 29) == 0) vblank = !vblank;
      vga_x = 10'($urandom_range(0, H + 2));
      vga_y = 9'($urandom_range(0, V + 2));
      @(negedge clk);
    end
    cyc();
    wait_clear_done("rand_clear_done");
    // asynchronous reset in the middle of a clear
    clear_req = 1; clear_color = 6'h2a; vga_x = 3; vga_y = 1;
    cyc(100);
    #2 rst = 1;
    #1;
    chk("arst_we", we_2, 0);
    chk("arst_busy", clear_busy, 0);
    chk("arst_front", front_sel, 0);
    chk("arst_read", read_addr, 0);
    chk("arst_pend", swap_pending, 0);
    cyc();
    rst = 0;
    clear_req = 1; clear_color = 6'h07;
    cyc(2);
    chk("restart_addr", write_addr, FB);
    wait_clear_done("restart_done");
    cyc(3);
    chk("queue_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
